data_sram_bridge: RTL and testbench

- Sits directly downstream of the CPU core's data port.
- The core issues a load/store in EX and expects read data in MEM one cycle later. The bridge turns this single-cycle data_sram_* port into a variable-latency req/addr_ok/data_ok handshake toward the memory side.
- It asserts a stall request to CTRL while a transaction is in flight, and holds the returned read data for MEM.

---
 rtl/data_sram_bridge.sv | 115 +++++++++++
 tb/tb_data_sram_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the core's single-cycle data_sram_* port into a
// req/addr_ok/data_ok bus transaction, stalling the pipeline while in flight
// and holding the last load's data for MEM.
module data_sram_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq_mem,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic              wr_c;
    logic [1:0]        size_c;
    logic [ADDR_W-1:0] addr_c;

    // Decode the core access into bus request fields; odd enable patterns fall back to a word.
    always_comb begin
        wr_c   = (data_sram_wen != BE_W'(0));
        size_c = 2'd2;
        if (wr_c) begin
            case (data_sram_wen)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: size_c = 2'd0;
                4'b0011, 4'b1100:                   size_c = 2'd1;
                default:                            size_c = 2'd2;
            endcase
        end
        addr_c = wr_c ? data_sram_addr : {data_sram_addr[ADDR_W-1:2], 2'b00};
    end

    // Hold the pipeline from EX entry until the transaction completes; released in DONE.
    assign stallreq_mem = rst && (((state == IDLE) && data_sram_en) ||
                                  (state == REQ) || (state == WAIT));

    // Transaction FSM with registered bus outputs and load-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            req             <= 1'b0;
            wr              <= 1'b0;
            size            <= 2'd0;
            addr            <= '0;
            wdata           <= '0;
            data_sram_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        req   <= 1'b1;
                        wr    <= wr_c;
                        size  <= size_c;
                        addr  <= addr_c;
                        wdata <= data_sram_wdata;
                        state <= REQ;
                    end
                end
                REQ: begin
                    // data_ok without addr_ok is a protocol error and is ignored
                    if (addr_ok) begin
                        req <= 1'b0;
                        if (data_ok) begin
                            state <= DONE;
                            if (!wr) begin
                                data_sram_rdata <= rdata;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_ok) begin
                        state <= DONE;
                        if (!wr) begin
                            data_sram_rdata <= rdata;
                        end
                    end
                end
                DONE: begin
                    // EX still shows the finished access this cycle; do not reissue it
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: a transaction-timeline model
// predicts every output per cycle from the chosen bus delays.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        stallreq_mem;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] bus_rdata;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (core_addr),
        .data_sram_wdata (core_wdata),
        .data_sram_rdata (core_rdata),
        .stallreq_mem    (stallreq_mem),
        .req             (req),
        .wr              (wr),
        .size            (size),
        .addr            (addr),
        .wdata           (wdata),
        .addr_ok         (addr_ok),
        .data_ok         (data_ok),
        .rdata           (bus_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected outputs for the current cycle
    logic        check_en = 1'b0;
    logic        exp_req, exp_stall, exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [31:0] model_rdata;

    // observation counters for literal checks
    int          hs_count, req_cnt, stall_cnt;
    logic [31:0] seen_addr;
    logic [1:0]  seen_size;
    logic        seen_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [1:0] model_size(input logic [3:0] w);
        if (w == 4'b0000) return 2'd2;
        if (w == 4'b0001 || w == 4'b0010 || w == 4'b0100 || w == 4'b1000) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_addr(input logic [3:0] w, input logic [31:0] a);
        return (w == 4'b0000) ? (a & 32'hFFFF_FFFC) : a;
    endfunction

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("req", 32'(req), 32'(exp_req));
            chk("stallreq_mem", 32'(stallreq_mem), 32'(exp_stall));
            chk("data_sram_rdata", core_rdata, exp_rdata);
            if (exp_req) begin
                chk("wr", 32'(wr), 32'(exp_wr));
                chk("size", 32'(size), 32'(exp_size));
                chk("addr", addr, exp_addr);
                chk("wdata", wdata, exp_wdata);
            end
            if (req && addr_ok) hs_count++;
            if (req) begin
                req_cnt++;
                seen_addr = addr;
                seen_size = size;
                seen_wr   = wr;
            end
            if (stallreq_mem) stall_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            en = 1'b0; wen = $urandom; core_addr = $urandom; core_wdata = $urandom;
            addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = $urandom;
            exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = model_rdata;
        end
    endtask

    // one core access: ad cycles before addr_ok, dd cycles from addr_ok to data_ok
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                          input int ad, input int dd, input bit stray, input logic [31:0] rd);
        logic [31:0] cap;
        cap = 32'h0;
        @(posedge clk); #1;
        req_cnt = 0; stall_cnt = 0;
        en = 1'b1; wen = w; core_addr = a; core_wdata = wd;
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = $urandom;
        exp_req = 1'b0; exp_stall = 1'b1; exp_rdata = model_rdata;
        exp_wr = (w != 4'b0000); exp_size = model_size(w);
        exp_addr = model_addr(w, a); exp_wdata = wd;
        for (int j = 0; j <= ad; j++) begin
            @(posedge clk); #1;
            exp_req = 1'b1; exp_stall = 1'b1;
            addr_ok = (j == ad);
            data_ok = ((j == ad) && (dd == 0)) || ((j < ad) && stray);
            bus_rdata = $urandom;
            if ((j == ad) && (dd == 0)) begin
                bus_rdata = rd; cap = rd;
            end
        end
        for (int i = 1; i <= dd; i++) begin
            @(posedge clk); #1;
            exp_req = 1'b0; exp_stall = 1'b1;
            addr_ok = 1'b0; data_ok = (i == dd); bus_rdata = $urandom;
            if (i == dd) begin
                bus_rdata = rd; cap = rd;
            end
        end
        // DONE: EX still presents the same access
        @(posedge clk); #1;
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = $urandom;
        if (w == 4'b0000) model_rdata = cap;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = model_rdata;
    endtask

    logic [3:0] wen_pool [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0011, 4'b1100, 4'b1111, 4'b0110, 4'b0101};

    initial begin
        rst = 1'b0; en = 1'b0; wen = 4'b0; core_addr = 32'h0; core_wdata = 32'h0;
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'h0;
        model_rdata = 32'h0; hs_count = 0; req_cnt = 0; stall_cnt = 0;
        seen_addr = 32'h0; seen_size = 2'd0; seen_wr = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = 32'h0;
        exp_wr = 1'b0; exp_size = 2'd0; exp_addr = 32'h0; exp_wdata = 32'h0;
        #2;
        chk("reset req", 32'(req), 32'h0);
        chk("reset stall", 32'(stallreq_mem), 32'h0);
        chk("reset rdata", core_rdata, 32'h0);
        chk("reset bus fields", {wr, size, 29'(addr | wdata)}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check_en = 1'b1;
        idle(2);

        // zero-wait read
        access(4'b0000, 32'h8000_0006, 32'h1234_5678, 0, 0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("read addr", seen_addr, 32'h8000_0004);
        chk("read size", 32'(seen_size), 32'd2);
        chk("read wr", 32'(seen_wr), 32'd0);
        chk("read stall cycles", 32'(stall_cnt), 32'd2);
        chk("read data", core_rdata, 32'hDEAD_BEEF);
        idle(1);

        // byte store with waits
        access(4'b0100, 32'h0000_1002, 32'h00AB_0000, 2, 3, 1'b0, 32'h5555_AAAA);
        @(negedge clk); #1;
        chk("bstore req cycles", 32'(req_cnt), 32'd3);
        chk("bstore addr", seen_addr, 32'h0000_1002);
        chk("bstore size", 32'(seen_size), 32'd0);
        chk("bstore wr", 32'(seen_wr), 32'd1);
        chk("bstore stall cycles", 32'(stall_cnt), 32'd7);
        chk("bstore rdata kept", core_rdata, 32'hDEAD_BEEF);

        // half and word stores
        access(4'b1100, 32'h0000_2002, 32'hBEEF_0000, 0, 1, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("hstore size", 32'(seen_size), 32'd1);
        access(4'b1111, 32'h0000_2004, 32'hCAFE_F00D, 1, 0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("wstore size", 32'(seen_size), 32'd2);

        // back-to-back load then store
        idle(1);
        hs_count = 0;
        access(4'b0000, 32'h0000_3000, 32'h0, 1, 1, 1'b0, 32'h0BAD_F00D);
        access(4'b0011, 32'h0000_3000, 32'h0000_1357, 0, 2, 1'b0, 32'h0);
        idle(1);
        chk("b2b handshakes", 32'(hs_count), 32'd2);
        chk("b2b load data", core_rdata, 32'h0BAD_F00D);

        // stray data_ok in REQ
        access(4'b0000, 32'h0000_4008, 32'h0, 3, 1, 1'b1, 32'h2468_ACE0);
        @(negedge clk); #1;
        chk("stray req cycles", 32'(req_cnt), 32'd4);
        chk("stray load data", core_rdata, 32'h2468_ACE0);

        // reset during WAIT
        @(posedge clk); #1;
        en = 1'b1; wen = 4'b0000; core_addr = 32'h0000_5000; core_wdata = 32'h0;
        exp_req = 1'b0; exp_stall = 1'b1; exp_rdata = model_rdata;
        exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h0000_5000; exp_wdata = 32'h0;
        @(posedge clk); #1;
        addr_ok = 1'b1; exp_req = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0; exp_req = 1'b0;
        @(posedge clk); #2;
        check_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("async rst req", 32'(req), 32'h0);
        chk("async rst stall", 32'(stallreq_mem), 32'h0);
        chk("async rst rdata", core_rdata, 32'h0);
        model_rdata = 32'h0;
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = model_rdata;
        check_en = 1'b1;
        access(4'b0000, 32'h0000_6001, 32'h0, 1, 2, 1'b0, 32'h7777_1111);
        @(negedge clk); #1;
        chk("post-reset load", core_rdata, 32'h7777_1111);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [3:0] w;
            int ad;
            w  = wen_pool[$urandom_range(0, 9)];
            ad = $urandom_range(0, 3);
            access(w, $urandom, $urandom, ad, $urandom_range(0, 3),
                   (ad > 0) && ($urandom_range(0, 1) == 1), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(2);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
